// File: rtl/tge_app_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tge_app_pkt_gen
// Purpose  : Application-side traffic source for the 10GbE core transmit
//            interface. Emits sequence-numbered UDP payload frames:
//              word 0        : {MAGIC, seq}
//              words 1..N    : {seq, 16'h0, index}
//              (optional)    : 64-bit XOR of header and payload words
//            followed by a forced inter-frame gap.
// Options  : TGE_PKT_GEN_CHECKSUM_EN - append an XOR checksum word; the
//            end-of-frame marker moves onto that word.
// Ports    : clk, rst (async, active-high)
//            enable, dest_ip, dest_port           - control / addressing
//            tx_valid, tx_end_of_frame, tx_data,
//            tx_dest_ip, tx_dest_port             - to core (registered)
//            tx_afull, tx_overflow                - from core
//            busy, frames_sent, overflow_count    - status
// Revision : 1.0 - initial release
// ============================================================================
module tge_app_pkt_gen #(
    parameter int          PAYLOAD_WORDS = 128,
    parameter int          GAP_CYCLES    = 16,
    parameter logic [31:0] MAGIC         = 32'h5447_4547
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] dest_ip,
    input  logic [15:0] dest_port,
    output logic        tx_valid,
    output logic        tx_end_of_frame,
    output logic [63:0] tx_data,
    output logic [31:0] tx_dest_ip,
    output logic [15:0] tx_dest_port,
    input  logic        tx_afull,
    input  logic        tx_overflow,
    output logic        busy,
    output logic [31:0] frames_sent,
    output logic [15:0] overflow_count
);

    localparam logic [15:0] c_last_idx = 16'(PAYLOAD_WORDS - 1);
    localparam logic [31:0] c_gap_load = 32'(GAP_CYCLES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        PAY  = 3'd2,
        GAP  = 3'd3
`ifdef TGE_PKT_GEN_CHECKSUM_EN
        ,
        CSUM = 3'd4
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] seq_q, seq_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] gap_q, gap_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_eof_q, tx_eof_d;
    logic [63:0] tx_data_q, tx_data_d;
    logic [31:0] tx_dest_ip_q, tx_dest_ip_d;
    logic [15:0] tx_dest_port_q, tx_dest_port_d;
    logic [31:0] frames_sent_q, frames_sent_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
`ifdef TGE_PKT_GEN_CHECKSUM_EN
    logic [63:0] csum_q, csum_d;
`endif

    logic [63:0] w_hdr_word;
    logic [63:0] w_pay_word;

    assign w_hdr_word = {MAGIC, seq_q};
    assign w_pay_word = {seq_q, 16'h0000, idx_q};

    always_comb begin
        state_d        = state_q;
        seq_d          = seq_q;
        idx_d          = idx_q;
        gap_d          = gap_q;
        tx_valid_d     = 1'b0;
        tx_eof_d       = 1'b0;
        tx_data_d      = tx_data_q;
        tx_dest_ip_d   = tx_dest_ip_q;
        tx_dest_port_d = tx_dest_port_q;
        frames_sent_d  = frames_sent_q;
`ifdef TGE_PKT_GEN_CHECKSUM_EN
        csum_d         = csum_q;
`endif
        // Saturating count of overflow cycles; only reset clears it.
        ovf_cnt_d = (tx_overflow && (ovf_cnt_q != 16'hFFFF)) ? ovf_cnt_q + 16'd1 : ovf_cnt_q;

        case (state_q)
            IDLE: begin
                if (enable && !tx_afull) begin
                    tx_dest_ip_d   = dest_ip;
                    tx_dest_port_d = dest_port;
                    state_d        = HDR;
                end
            end
            HDR: begin
                if (!tx_afull) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = w_hdr_word;
                    idx_d      = 16'd0;
`ifdef TGE_PKT_GEN_CHECKSUM_EN
                    csum_d     = w_hdr_word;
`endif
                    state_d    = PAY;
                end
            end
            PAY: begin
                if (!tx_afull) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = w_pay_word;
                    idx_d      = idx_q + 16'd1;
`ifdef TGE_PKT_GEN_CHECKSUM_EN
                    csum_d     = csum_q ^ w_pay_word;
                    if (idx_q == c_last_idx) begin
                        state_d = CSUM;
                    end
`else
                    if (idx_q == c_last_idx) begin
                        tx_eof_d      = 1'b1;
                        seq_d         = seq_q + 32'd1;
                        frames_sent_d = frames_sent_q + 32'd1;
                        gap_d         = c_gap_load;
                        state_d       = GAP;
                    end
`endif
                end
            end
`ifdef TGE_PKT_GEN_CHECKSUM_EN
            CSUM: begin
                if (!tx_afull) begin
                    tx_valid_d    = 1'b1;
                    tx_eof_d      = 1'b1;
                    tx_data_d     = csum_q;
                    seq_d         = seq_q + 32'd1;
                    frames_sent_d = frames_sent_q + 32'd1;
                    gap_d         = c_gap_load;
                    state_d       = GAP;
                end
            end
`endif
            GAP: begin
                // Counter reaching zero (or already zero) ends the gap, so a
                // zero-length gap still spends exactly one cycle here.
                if (gap_q <= 32'd1) begin
                    gap_d   = 32'd0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            seq_q          <= 32'd0;
            idx_q          <= 16'd0;
            gap_q          <= 32'd0;
            tx_valid_q     <= 1'b0;
            tx_eof_q       <= 1'b0;
            tx_data_q      <= 64'd0;
            tx_dest_ip_q   <= 32'd0;
            tx_dest_port_q <= 16'd0;
            frames_sent_q  <= 32'd0;
            ovf_cnt_q      <= 16'd0;
`ifdef TGE_PKT_GEN_CHECKSUM_EN
            csum_q         <= 64'd0;
`endif
        end else begin
            state_q        <= state_d;
            seq_q          <= seq_d;
            idx_q          <= idx_d;
            gap_q          <= gap_d;
            tx_valid_q     <= tx_valid_d;
            tx_eof_q       <= tx_eof_d;
            tx_data_q      <= tx_data_d;
            tx_dest_ip_q   <= tx_dest_ip_d;
            tx_dest_port_q <= tx_dest_port_d;
            frames_sent_q  <= frames_sent_d;
            ovf_cnt_q      <= ovf_cnt_d;
`ifdef TGE_PKT_GEN_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    assign tx_valid        = tx_valid_q;
    assign tx_end_of_frame = tx_eof_q;
    assign tx_data         = tx_data_q;
    assign tx_dest_ip      = tx_dest_ip_q;
    assign tx_dest_port    = tx_dest_port_q;
    assign frames_sent     = frames_sent_q;
    assign overflow_count  = ovf_cnt_q;
    assign busy            = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tge_app_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_tge_app_pkt_gen
// Purpose  : Self-checking bench for tge_app_pkt_gen (PAYLOAD_WORDS=4,
//            GAP_CYCLES=2). Expected frames are queued before the DUT can
//            emit them; a monitor pops and compares every valid word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tge_app_pkt_gen;

    localparam int          PW    = 4;
    localparam int          GAP   = 2;
    localparam logic [31:0] MAGIC = 32'h5447_4547;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] dest_ip;
    logic [15:0] dest_port;
    logic        tx_valid;
    logic        tx_end_of_frame;
    logic [63:0] tx_data;
    logic [31:0] tx_dest_ip;
    logic [15:0] tx_dest_port;
    logic        tx_afull;
    logic        tx_overflow;
    logic        busy;
    logic [31:0] frames_sent;
    logic [15:0] overflow_count;

    typedef struct {
        logic [63:0] data;
        logic        eof;
        logic [31:0] ip;
        logic [15:0] port;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    tge_app_pkt_gen #(
        .PAYLOAD_WORDS(PW),
        .GAP_CYCLES   (GAP),
        .MAGIC        (MAGIC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .dest_ip        (dest_ip),
        .dest_port      (dest_port),
        .tx_valid       (tx_valid),
        .tx_end_of_frame(tx_end_of_frame),
        .tx_data        (tx_data),
        .tx_dest_ip     (tx_dest_ip),
        .tx_dest_port   (tx_dest_port),
        .tx_afull       (tx_afull),
        .tx_overflow    (tx_overflow),
        .busy           (busy),
        .frames_sent    (frames_sent),
        .overflow_count (overflow_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Queue the words of one frame with hand-derived contents.
    task automatic push_frame(input logic [31:0] seq, input logic [31:0] ip, input logic [15:0] port);
        exp_t        e;
        logic [63:0] x;
        e.ip   = ip;
        e.port = port;
        e.eof  = 1'b0;
        e.data = {MAGIC, seq};
        x      = e.data;
        exp_q.push_back(e);
        for (int i = 0; i < PW; i++) begin
            e.data = {seq, 16'h0000, 16'(i)};
            x      = x ^ e.data;
`ifdef TGE_PKT_GEN_CHECKSUM_EN
            e.eof  = 1'b0;
`else
            e.eof  = (i == PW - 1);
`endif
            exp_q.push_back(e);
        end
`ifdef TGE_PKT_GEN_CHECKSUM_EN
        e.data = x;
        e.eof  = 1'b1;
        exp_q.push_back(e);
`endif
    endtask

    // Bounded wait for a valid word (optionally the end-of-frame word);
    // returns the number of falling edges waited, or -1 on timeout.
    task automatic wait_valid(input string name, input bit need_eof, output int cycles);
        cycles = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (tx_valid && (!need_eof || tx_end_of_frame)) begin
                cycles = k;
                return;
            end
        end
        n_checks++;
        $display("FAIL %s: got timeout expected valid word", name);
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && tx_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %h expected no word", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", tx_data, e.data);
                    chk("word_eof_dest", {15'd0, tx_end_of_frame, tx_dest_ip, tx_dest_port},
                        {15'd0, e.eof, e.ip, e.port});
                end
            end
        end
    end

    initial begin
        int k;
        rst         = 1'b1;
        enable      = 1'b0;
        dest_ip     = 32'h0A00_0002;
        dest_port   = 16'h2710;
        tx_afull    = 1'b0;
        tx_overflow = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_valid_eof", {62'd0, tx_valid, tx_end_of_frame}, 64'd0);
        chk("rst_data", tx_data, 64'd0);
        chk("rst_dest", {16'd0, tx_dest_ip, tx_dest_port}, 64'd0);
        chk("rst_counts", {16'd0, frames_sent, overflow_count}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        // Back-to-back frames, seq 0 and 1
        push_frame(32'd0, 32'h0A00_0002, 16'h2710);
        push_frame(32'd1, 32'h0A00_0002, 16'h2710);
        rst    = 1'b0;
        enable = 1'b1;
        wait_valid("eof0_wait", 1'b1, k);
        chk("frames_after_f0", {32'd0, frames_sent}, 64'd1);
        chk("dest_ip_f0", {32'd0, tx_dest_ip}, 64'h0A00_0002);
        wait_valid("hdr1_wait", 1'b0, k);
        chk("hdr_spacing", 64'(k), 64'd4);

        // Header seq1 visible; step to payload word 1, then stall word 2,
        // drop enable and change the destination mid-frame.
        @(negedge clk);
        @(negedge clk);
        tx_afull  = 1'b1;
        enable    = 1'b0;
        dest_ip   = 32'hDEAD_BEEF;
        dest_port = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("afull_stall", {63'd0, tx_valid}, 64'd0);
        end
        tx_afull = 1'b0;
        wait_valid("eof1_wait", 1'b1, k);
        chk("frames_after_f1", {32'd0, frames_sent}, 64'd2);
        @(negedge clk);
        chk("busy_in_gap", {63'd0, busy}, 64'd1);
        @(negedge clk);
        chk("busy_after_gap", {63'd0, busy}, 64'd0);
        repeat (20) @(negedge clk);
        chk("queue_drained_1", 64'(exp_q.size()), 64'd0);

        // Overflow counting and saturation
        tx_overflow = 1'b1;
        repeat (5) @(negedge clk);
        tx_overflow = 1'b0;
        chk("ovf_count_5", {48'd0, overflow_count}, 64'd5);
        tx_overflow = 1'b1;
        repeat (70000) @(negedge clk);
        tx_overflow = 1'b0;
        @(negedge clk);
        chk("ovf_saturate", {48'd0, overflow_count}, 64'hFFFF);

        // Reset mid-payload
        dest_ip   = 32'hC0A8_0001;
        dest_port = 16'h1234;
        push_frame(32'd2, 32'hC0A8_0001, 16'h1234);
        enable = 1'b1;
        wait_valid("hdr2_wait", 1'b0, k);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid_eof", {62'd0, tx_valid, tx_end_of_frame}, 64'd0);
        chk("async_rst_data", tx_data, 64'd0);
        chk("async_rst_frames", {32'd0, frames_sent}, 64'd0);
        chk("async_rst_ovf_busy", {47'd0, overflow_count, busy}, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);

        // After release the sequence restarts at 0
        push_frame(32'd0, 32'hC0A8_0001, 16'h1234);
        rst = 1'b0;
        wait_valid("eof_post_rst_wait", 1'b1, k);
        enable = 1'b0;
        chk("frames_post_rst", {32'd0, frames_sent}, 64'd1);
        repeat (20) @(negedge clk);
        chk("queue_drained_2", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
